// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins, the long-latency unit takes idle slots.
// Tracks the LU destination scoreboard, raises RAW stalls, and requests a pipeline hold when the LU starves.
module rf_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4,
    parameter int MAX_OUT  = 2,
    localparam int NREG    = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ready,
    input  logic              rd_en_1,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic              rd_en_2,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic              raw_stall,
    output logic              stall_req,
    output logic [NREG-1:0]   busy_mask,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    // state  | meaning
    // IDLE   | LU not blocked
    // WAIT   | LU blocked by WB, counting consecutive blocked cycles
    // FORCE  | LU blocked for MAX_WAIT cycles, stall_req asserted
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam int OCW = 4;

    state_t           state, state_nxt;
    logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;
    logic [OCW-1:0]   out_cnt, out_cnt_nxt;
    logic [NREG-1:0]  busy_nxt, set_vec, clr_vec;
    logic             lu_grant, iss_fire, blocked, hit_1, hit_2;

    always_comb begin
        lu_grant  = !rst && lu_valid && !wb_en;
        rf_we     = !rst && (wb_en || lu_valid);
        rf_waddr  = '0;
        rf_wdata  = '0;
        if (!rst && wb_en) begin
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
        end else if (lu_grant) begin
            rf_waddr = lu_addr;
            rf_wdata = lu_data;
        end
        lu_ready  = lu_grant;
        iss_ready = !rst && (out_cnt < OCW'(MAX_OUT));
        iss_fire  = iss_valid && iss_ready;
    end

    // A read of the register being written by the LU this cycle is bypassed by the regfile.
    always_comb begin
        hit_1 = rd_en_1 && (rd_addr_1 != '0) && busy_mask[rd_addr_1]
                && !(lu_grant && (lu_addr == rd_addr_1));
        hit_2 = rd_en_2 && (rd_addr_2 != '0) && busy_mask[rd_addr_2]
                && !(lu_grant && (lu_addr == rd_addr_2));
        raw_stall = !rst && (hit_1 || hit_2);
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_fire && (iss_addr != '0)) set_vec[iss_addr] = 1'b1;
        if (lu_grant && (lu_addr != '0))  clr_vec[lu_addr]  = 1'b1;
        busy_nxt = (busy_mask & ~clr_vec) | set_vec;

        out_cnt_nxt = out_cnt;
        if (iss_fire && !lu_grant)
            out_cnt_nxt = out_cnt + OCW'(1);
        else if (!iss_fire && lu_grant && (out_cnt != '0))
            out_cnt_nxt = out_cnt - OCW'(1);
    end

    always_comb begin
        blocked      = lu_valid && wb_en;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (blocked) begin
                    wait_cnt_nxt = WCW'(1);
                    state_nxt    = (MAX_WAIT <= 1) ? S_FORCE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!blocked) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = S_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                    if (wait_cnt_nxt >= WCW'(MAX_WAIT)) state_nxt = S_FORCE;
                end
            end
            S_FORCE: begin
                if (!blocked) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = S_IDLE;
                end
            end
            default: begin
                wait_cnt_nxt = '0;
                state_nxt    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            out_cnt   <= '0;
            busy_mask <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            out_cnt   <= out_cnt_nxt;
            busy_mask <= busy_nxt;
        end
    end

    assign stall_req = !rst && (state == S_FORCE);

endmodule
